// File: rtl/program_loader.sv
// Boot loader: streams instruction words into memory from BASE_ADDR,
// holding the CPU in reset until the program is loaded.
module program_loader #(
    parameter int MAXMEMORY   = 4095,
    parameter int BASE_ADDR   = 0,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // 17-bit counter so a full 64K memory never wraps
    localparam logic [16:0] BASE17 = 17'(BASE_ADDR);
    localparam logic [16:0] MAX17  = 17'(MAXMEMORY);
    localparam logic [15:0] HOLD16 = 16'(HOLD_CYCLES);

    logic [2:0]  state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        wc_d    = wc_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = BASE17;
                    wc_d    = 16'd0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q <= MAX17) begin
                        addr_d = cnt_q[15:0];
                        data_d = in_data;
                        we_d   = 1'b1;
                        cnt_d  = cnt_q + 17'd1;
                        wc_d   = wc_q + 16'd1;
                        if (in_last) begin
                            state_d = S_HOLD;
                            hold_d  = HOLD16;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == 16'd0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= BASE17;
            addr_q  <= BASE17[15:0];
            data_q  <= 16'd0;
            we_q    <= 1'b0;
            wc_q    <= 16'd0;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            wc_q    <= wc_d;
            hold_q  <= hold_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign mem_sel    = (state_q != S_RUN);
    assign cpu_reset  = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_we     = we_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a default instance (A) and a
// small-memory instance (B, MAXMEMORY=7, BASE_ADDR=4) for overflow.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;

    logic        rdy_a, we_a, sel_a, cpu_a, done_a, err_a;
    logic [15:0] addr_a, data_a, wc_a;
    logic        rdy_b, we_b, sel_b, cpu_b, done_b, err_b;
    logic [15:0] addr_b, data_b, wc_b;

    always #5 clk = ~clk;

    program_loader u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_a), .mem_addr(addr_a), .mem_data(data_a),
        .mem_we(we_a), .mem_sel(sel_a), .cpu_reset(cpu_a),
        .done(done_a), .error(err_a), .word_count(wc_a)
    );

    program_loader #(.MAXMEMORY(7), .BASE_ADDR(4), .HOLD_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_b), .mem_addr(addr_b), .mem_data(data_b),
        .mem_we(we_b), .mem_sel(sel_b), .cpu_reset(cpu_b),
        .done(done_b), .error(err_b), .word_count(wc_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] mem_a [0:63];
    logic [15:0] ref_a [0:63];

    // reference model: next word index and overflow flag per instance
    int  a_idx;
    int  b_idx;
    bit  b_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    // instruction memory seen by instance A
    always @(posedge clk) begin
        if (we_a === 1'b1) mem_a[addr_a[5:0]] <= data_a;
    end

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_a unexpected addr %0h data %0h",
                         addr_a, data_a);
            end else begin
                chk("wr_a", {addr_a, data_a}, qa.pop_front());
            end
        end
        if (we_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_b unexpected addr %0h data %0h",
                         addr_b, data_b);
            end else begin
                chk("wr_b", {addr_b, data_b}, qb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit b);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // one valid cycle; the model decides whether it is a write
    task automatic send(input bit b, input logic [15:0] d, input bit last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (!b) begin
            qa.push_back({16'(a_idx), d});
            ref_a[a_idx] = d;
            a_idx++;
        end else if (!b_err) begin
            if (4 + b_idx <= 7) begin
                qb.push_back({16'(4 + b_idx), d});
                b_idx++;
            end else begin
                b_err = 1'b1;
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        tick();
        in_last  = 1'b0;
    endtask

    // edges from the last transfer until cpu_reset falls
    task automatic wait_release(input bit b, input int exp_n,
                                input string nm);
        int n = 0;
        while (((b ? cpu_b : cpu_a) !== 1'b0) && n < 20) begin
            tick();
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    initial begin
        logic [15:0] w;
        int bad;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        in_valid = 1'b0;
        in_data = 16'd0;
        in_last = 1'b0;
        a_idx = 0;
        b_idx = 0;
        b_err = 1'b0;
        repeat (2) tick();

        chk("rst_rdy", rdy_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_sel", sel_a, 1);
        chk("rst_cpu", cpu_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_wc", wc_a, 0);
        chk("rst_addr_b", addr_b, 4);
        reset = 1'b0;
        tick();

        // 20-word load, start pulsed during LOAD and HOLD
        pulse(1'b0);
        chk("start_rdy", rdy_a, 1);
        a_idx = 0;
        for (int i = 0; i < 20; i++) begin
            w = (i == 0) ? 16'hB010 : (i == 1) ? 16'hEA00 : 16'($urandom);
            if (i == 10) start_a = 1'b1;
            send(1'b0, w, i == 19);
            start_a = 1'b0;
        end
        start_a = 1'b1;
        chk("hold_cpu", cpu_a, 1);
        chk("hold_rdy", rdy_a, 0);
        tick();
        start_a = 1'b0;
        wait_release(1'b0, 2, "release20");
        chk("run_sel", sel_a, 0);
        chk("run_done", done_a, 1);
        chk("run_wc", wc_a, 20);
        chk("run_rdy", rdy_a, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) if (mem_a[i] !== ref_a[i]) bad++;
        chk("mem_stream", bad, 0);

        // restart from RUN: 2-word reload
        pulse(1'b0);
        chk("rerun_cpu", cpu_a, 1);
        chk("rerun_sel", sel_a, 1);
        chk("rerun_wc", wc_a, 0);
        a_idx = 0;
        send(1'b0, 16'($urandom), 1'b0);
        send(1'b0, 16'($urandom), 1'b1);
        wait_release(1'b0, 3, "release2");
        chk("reload_wc", wc_a, 2);

        // in_valid toggled every cycle during a 5-word load
        pulse(1'b0);
        a_idx = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 16'($urandom), i == 4);
            if (i != 4) idle_cycle();
        end
        wait_release(1'b0, 3, "release5");
        chk("toggle_wc", wc_a, 5);
        chk("toggle_q", qa.size(), 0);

        // reset after 3 of 10 words
        pulse(1'b0);
        a_idx = 0;
        for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rdy", rdy_a, 0);
        chk("mid_we", we_a, 0);
        chk("mid_addr", addr_a, 0);
        chk("mid_cpu", cpu_a, 1);
        chk("mid_wc", wc_a, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) if (mem_a[i] !== ref_a[i]) bad++;
        chk("mem_keep", bad, 0);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("idle_rdy", rdy_a, 0);

        // overflow on the small instance
        pulse(1'b1);
        b_idx = 0;
        b_err = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b1, 16'($urandom), 1'b0);
        chk("ovf_err", err_b, 1);
        chk("ovf_wc", wc_b, 4);
        chk("ovf_cpu", cpu_b, 1);
        chk("ovf_rdy", rdy_b, 0);
        chk("ovf_q", qb.size(), 0);

        // restart from ERR with a single-word program
        pulse(1'b1);
        chk("err_clr", err_b, 0);
        b_idx = 0;
        b_err = 1'b0;
        send(1'b1, 16'($urandom), 1'b1);
        wait_release(1'b1, 3, "release1");
        chk("one_wc", wc_b, 1);
        chk("one_done", done_b, 1);

        repeat (3) tick();
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
